// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared encodings for the UART transmit frame sequencer
package uart_tx_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_DATA  = 2'd1;
  localparam logic [1:0] SEL_PAR   = 2'd2;
  localparam logic [1:0] SEL_STOP  = 2'd3;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;
endpackage

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: even/odd parity of a payload word
module uart_tx_parity #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);
  assign par_bit = ^data ^ par_typ;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame sequencer driving the serializer load and the output mux
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_ack,
  output logic [DATA_WIDTH-1:0] p_data_q,
  output logic                  ser_en,
  input  logic                  ser_done,
  output logic                  par_bit,
  output logic [1:0]            mux_sel,
  output logic                  busy
);
  state_e                  state_q, state_d;
  logic                    acc, par_calc;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    tx_ack_q, tx_ack_d;
  logic                    ser_en_q, ser_en_d;
  logic                    busy_q, busy_d;
  logic [1:0]              mux_sel_q, mux_sel_d;
  logic [DATA_WIDTH-1:0]   p_data_d;
  uart_tx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data    (p_data),
    .par_typ (par_typ),
    .par_bit (par_calc)
  );
  // Outputs are derived from the next state so they line up with state_q after the edge.
  always_comb begin
    acc = (state_q == IDLE || state_q == STOP) && data_valid;
    case (state_q)
      IDLE:    state_d = acc ? START : IDLE;
      START:   state_d = DATA;
      DATA:    state_d = ser_done ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_d = STOP;
      STOP:    state_d = acc ? START : IDLE;
      default: state_d = IDLE;
    endcase
    mux_sel_d = state_d == START  ? SEL_START :
                state_d == DATA   ? SEL_DATA  :
                state_d == PARITY ? SEL_PAR   : SEL_STOP;
    busy_d    = state_d != IDLE;
    ser_en_d  = state_d == START;
    tx_ack_d  = acc;
    p_data_d  = acc ? p_data : p_data_q;
    par_en_d  = acc ? par_en : par_en_q;
    par_bit_d = acc ? par_calc : par_bit_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mux_sel_q <= SEL_STOP;
      busy_q    <= 1'b0;
      ser_en_q  <= 1'b0;
      tx_ack_q  <= 1'b0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      p_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      mux_sel_q <= mux_sel_d;
      busy_q    <= busy_d;
      ser_en_q  <= ser_en_d;
      tx_ack_q  <= tx_ack_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      p_data_q  <= p_data_d;
    end
  end
  assign tx_ack  = tx_ack_q;
  assign ser_en  = ser_en_q;
  assign par_bit = par_bit_q;
  assign mux_sel = mux_sel_q;
  assign busy    = busy_q;
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmitter.
- Accepts a parallel byte through a valid/ack handshake and latches it together with the parity configuration.
- Pulses the serializer load enable, then steps the output mux through start, data, parity (optional) and stop bits.
- Sits between the TX input interface and the serializer/output-mux datapath. Runs at bit rate: one clk = one bit period.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; the serializer instance uses the same value.

Ports:
- clk  in  1  bit-rate clock
- rst  in  1  asynchronous reset, active-high
- data_valid  in  1  upstream holds high while p_data is valid
- p_data  in  DATA_WIDTH  byte to transmit
- par_en  in  1  1 = parity bit inserted
- par_typ  in  1  0 = even, 1 = odd
- tx_ack  out  1  one-cycle pulse: p_data latched this cycle
- p_data_q  out  DATA_WIDTH  latched byte, drives serializer p_data
- ser_en  out  1  one-cycle serializer load pulse
- ser_done  in  1  serializer done flag (high while its bit counter is 0)
- par_bit  out  1  registered parity bit for the output mux
- mux_sel  out  2  output mux select (encoding in package)
- busy  out  1  frame in progress

Behaviour:
- Reset (async, immediate):
  - state = IDLE; mux_sel = SEL_STOP, so the line idles high.
  - busy = 0, ser_en = 0, tx_ack = 0, par_bit = 0, p_data_q = 0.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.
- Accept condition: (state == IDLE or state == STOP) and data_valid.
  - Same edge: p_data_q <= p_data; par_en/par_typ latched; par_bit <= ^p_data XOR par_typ; tx_ack = 1 for the next cycle; next state = START.
  - Inputs sampled outside an accept have no effect. Changing par_en/par_typ mid-frame does not affect the current frame.
- IDLE: mux_sel = SEL_STOP, busy = 0. Stays in IDLE until an accept.
- START (exactly 1 cycle): mux_sel = SEL_START, busy = 1, ser_en = 1. Next state = DATA. The serializer loads at the end of this cycle.
- DATA:
  - mux_sel = SEL_DATA, ser_en = 0.
  - Advances on a cycle in which ser_done = 1: to PARITY if the latched par_en = 1, else to STOP.
  - Nominal dwell is DATA_WIDTH cycles; ser_done rises in the last data cycle.
  - ser_done is ignored in every state except DATA.
  - ser_en is never asserted in DATA, so the serializer cannot reload mid-frame.
- PARITY (1 cycle): mux_sel = SEL_PAR. Next state = STOP.
- STOP (1 cycle): mux_sel = SEL_STOP, busy = 1.
  - With an accept: next state = START, giving back-to-back frames with no idle gap.
  - Otherwise: next state = IDLE.
- Frame length from START entry to STOP exit: DATA_WIDTH + 2 cycles without parity, DATA_WIDTH + 3 with parity.
- Latency: data_valid high in IDLE at edge N → tx_ack and START in cycle N+1 → first data bit on the line in cycle N+2.
- tx_ack: at most one pulse per frame. Upstream must drop data_valid, or present the next byte, in the cycle after tx_ack. A still-high data_valid at the next STOP is treated as a new byte.
- Reset mid-frame: returns to IDLE immediately; the line goes high via SEL_STOP. The partial frame is discarded and not retransmitted.
- Safety: an illegal state encoding recovers to IDLE on the next edge.

Decomposition:
- Package uart_tx_pkg:
  - mux_sel encoding: SEL_START = 2'd0 (line 0), SEL_DATA = 2'd1 (serializer bit), SEL_PAR = 2'd2 (par_bit), SEL_STOP = 2'd3 (line 1).
  - State encoding constants for IDLE/START/DATA/PARITY/STOP.
  - Default DATA_WIDTH.
- Sub-module uart_tx_parity: combinational parity of DATA_WIDTH bits with par_typ. Instantiated once and registered in uart_tx_ctrl.

Test Plan:
Each bench pairs uart_tx_ctrl with a behavioural serializer and output mux, and checks the line value per cycle.
1. p_data = 0xA5, par_en = 0, single data_valid pulse → tx_ack 1 cycle later; line = 0,1,0,1,0,0,1,0,1,1 (LSB first); busy high for exactly 10 cycles; then IDLE with line high.
2. p_data = 0xA5, par_en = 1, par_typ = 0 → par_bit = 0; 11-cycle frame with line = 0 in the parity slot. Repeat with par_typ = 1 → parity slot = 1.
3. data_valid held high, bytes 0x3C then 0xC3 (next byte presented after each tx_ack) → the second START immediately follows the first STOP; no idle cycle between frames; exactly two tx_ack pulses.
4. data_valid asserted and p_data/par_en toggled mid-frame (during DATA) → no tx_ack; current frame bits and length unchanged; the byte is accepted at STOP.
5. rst asserted during the 4th data bit → busy = 0, ser_en = 0 and mux_sel = SEL_STOP immediately (before the next clk edge); after release, a new byte 0x55 transmits as a complete, correct frame.
6. ser_done forced high while in IDLE, START and PARITY → no state change attributable to it; ser_en pulses exactly once per frame.
